// File: rtl/btn_pkg.sv
// Shared constants for the push-button debounce/capture slice.
// Holds the clock rate, default debounce window and counter sizing helper.
`timescale 1ns/1ps
package btn_pkg;

    localparam int CLK_HZ                  = 27_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 270_000;

    // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for tiny windows.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEBOUNCE_CNT_W = cnt_width(DEBOUNCE_CYCLES_DEFAULT);

    typedef struct packed {
        logic level;
        logic press;
        logic release_pulse;
    } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-bit debouncer: two-flop synchronizer, stability counter, accepted level
// and registered one-cycle press/release pulses. Raw input is active-low.
`timescale 1ns/1ps
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    logic             sample;
    logic             differ;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to the released (high) level so reset alone never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    assign sample = ~sync_2;
    assign differ = (sample != level);
    assign accept = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                // Pulses are registered alongside level so both appear in the same cycle.
                cnt           <= '0;
                level         <= ~level;
                press         <= ~level;
                release_pulse <= level;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/btn_latch_ctrl.sv
// Two debounced buttons: btn[0] gates a registered D-latch, btn[1] is the data it captures.
// Also exposes the debounced levels and per-button press/release pulses.
`timescale 1ns/1ps
module btn_latch_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    output logic [1:0] level,
    output logic [1:0] press,
    // `release` is a reserved word, hence release_pulse.
    output logic [1:0] release_pulse,
    output logic       q,
    output logic       q_n
);

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_gate (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn[0]),
        .level         (level[0]),
        .press         (press[0]),
        .release_pulse (release_pulse[0])
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_data (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn[1]),
        .level         (level[1]),
        .press         (press[1]),
        .release_pulse (release_pulse[1])
    );

    // Uses the pre-edge levels: when the gate falls, the old data value is the one kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (level[0]) begin
            q <= level[1];
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_btn_latch_ctrl.sv
// Directed bench for btn_latch_ctrl with a 4-cycle debounce window.
`timescale 1ns/1ps
module tb_btn_latch_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] release_pulse;
    logic       q;
    logic       q_n;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] cur_lvl;
    logic       cur_q;

    btn_latch_ctrl #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .q             (q),
        .q_n           (q_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                              input logic [1:0] rel, input logic qv);
        check({tag, ".level"},   level,          lvl);
        check({tag, ".press"},   press,          prs);
        check({tag, ".release"}, release_pulse,  rel);
        check({tag, ".q"},       {1'b0, q},      {1'b0, qv});
        check({tag, ".q_n"},     {1'b0, q_n},    {1'b0, ~qv});
    endtask

    // Apply a clean btn step; acceptance lands on the 6th edge after the change.
    task automatic step_to(input string tag, input logic [1:0] b, input logic [1:0] lvl_new,
                           input logic [1:0] prs, input logic [1:0] rel,
                           input logic q_edge, input logic q_after);
        btn = b;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 6)       expect_all(tag, cur_lvl, 2'b00, 2'b00, cur_q);
            else if (i == 6) expect_all(tag, lvl_new, prs, rel, q_edge);
            else             expect_all(tag, lvl_new, 2'b00, 2'b00, q_after);
        end
        cur_lvl = lvl_new;
        cur_q   = q_after;
    endtask

    initial begin
        cur_lvl = 2'b00;
        cur_q   = 1'b0;

        // Reset with both buttons released
        btn = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        expect_all("reset", 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        tick();
        expect_all("post_reset", 2'b00, 2'b00, 2'b00, 1'b0);

        // Clean press and release of the data button, gate closed
        step_to("press1",   2'b01, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
        step_to("release1", 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);

        // Bounce: low for 3 edges, high for 1, then stable low
        btn = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all("bounce_low", 2'b00, 2'b00, 2'b00, 1'b0);
        end
        btn = 2'b11;
        tick();
        expect_all("bounce_high", 2'b00, 2'b00, 2'b00, 1'b0);
        btn = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 6)       expect_all("bounce_settle", 2'b00, 2'b00, 2'b00, 1'b0);
            else if (i == 6) expect_all("bounce_settle", 2'b10, 2'b10, 2'b00, 1'b0);
            else             expect_all("bounce_settle", 2'b10, 2'b00, 2'b00, 1'b0);
        end
        cur_lvl = 2'b10;

        // Gate open: q follows data one cycle behind level
        step_to("gate_on",  2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1);
        step_to("data_off", 2'b10, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0);
        step_to("data_on",  2'b00, 2'b11, 2'b10, 2'b00, 1'b0, 1'b1);

        // Gate closed: q frozen while data toggles
        step_to("gate_off",   2'b01, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
        step_to("frozen_off", 2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
        step_to("frozen_on",  2'b01, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1);

        // Set up gate=1, data=0, q=0, then gate falls as data rises in one edge
        step_to("data_off2", 2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
        step_to("gate_on2",  2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0);
        step_to("simul",     2'b01, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0);
        step_to("clear",     2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);

        // Reset in the middle of a debounce, button kept held
        btn = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all("mid_count", 2'b00, 2'b00, 2'b00, 1'b0);
        end
        rst = 1'b1;
        tick();
        tick();
        expect_all("mid_rst", 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 6)       expect_all("after_rst", 2'b00, 2'b00, 2'b00, 1'b0);
            else if (i == 6) expect_all("after_rst", 2'b10, 2'b10, 2'b00, 1'b0);
            else             expect_all("after_rst", 2'b10, 2'b00, 2'b00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_latch_ctrl.md
BTN_LATCH_CTRL -- requirements
Module: btn_latch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000 (10 ms at 27 MHz), legal range >= 2; number of consecutive cycles a synchronized input must differ from the accepted level before the change is accepted.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 btn  input  2  raw asynchronous push-buttons, active-low (0 = pressed); btn[0] = enable/gate, btn[1] = data.
REQ-005 level  output  2  debounced button state, active-high (1 = pressed), one bit per button.
REQ-006 press  output  2  one-cycle pulse per button on the accepted 0->1 transition of level.
REQ-007 release  output  2  one-cycle pulse per button on the accepted 1->0 transition of level.
REQ-008 q  output  1  captured data bit.
REQ-009 q_n  output  1  always the inverse of q.

Function
REQ-010 Each btn bit SHALL pass through a two-flop synchronizer; the second-stage output SHALL be inverted to form the active-high sample s[i].
REQ-011 Each channel SHALL have an independent counter: cleared when s[i] == level[i]; incremented when s[i] != level[i].
REQ-012 When s[i] != level[i] and the counter equals DEBOUNCE_CYCLES-1, level[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-013 Any cycle with s[i] == level[i] before acceptance SHALL clear the counter; glitches shorter than DEBOUNCE_CYCLES cycles SHALL NOT change level.
REQ-014 Latency: a clean btn step stable from edge k SHALL change level[i] at edge k+1+DEBOUNCE_CYCLES, exactly.
REQ-015 press[i]/release[i] SHALL be registered and assert in the same cycle that level[i] first shows its new value, for exactly one cycle.
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-017 Capture: on every edge where the registered level[0] == 1, q SHALL load level[1] (transparent); while level[0] == 0, q SHALL hold (registered D-latch equivalent).
REQ-018 Simultaneous event: on the edge where level[0] falls, q SHALL load the pre-edge level[1]; a level[1] change in that same edge SHALL NOT be captured.
REQ-019 Channels SHALL be fully independent; simultaneous acceptance on both channels SHALL produce both pulses in the same cycle.

Reset
REQ-020 While rst == 1 at an edge: synchronizer flops = 1 (released), level = 0, counters = 0, press = release = 0, q = 0, q_n = 1.
REQ-021 Reset mid-debounce SHALL discard the partial count; no press/release pulse SHALL be generated by reset itself or on the first cycle after it.
REQ-022 A button held during reset SHALL be accepted as pressed DEBOUNCE_CYCLES+2 cycles after rst deasserts, with one press pulse.

Structure
REQ-023 Shared package btn_pkg SHALL hold DEBOUNCE_CYCLES_DEFAULT (270000), CLK_HZ (27000000) and the counter-width constant.
REQ-024 One sub-module btn_debounce (synchronizer, counter, level, press/release for a single bit) SHALL be instantiated twice; capture logic stays in btn_latch_ctrl.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Reset: assert rst 2 cycles with btn = 2'b11 -> level = 0, press = release = 0, q = 0, q_n = 1.
REQ-026 Clean press: btn[1] 1->0 stable from edge k -> level[1] = 1 and press[1] = 1 at edge k+5 only; release[1] = 0 throughout.
REQ-027 Bounce: btn[1] low 3 cycles, high 1, then low stable -> no pulse during the glitch; level[1] rises exactly 5 edges after the final stable low.
REQ-028 Capture: hold btn[0] pressed, toggle btn[1] -> q tracks level[1] with one cycle lag; release btn[0] -> q frozen while btn[1] keeps toggling; q_n == ~q every cycle.
REQ-029 Simultaneous: level[0] falls in the same edge that level[1] rises -> q keeps the old level[1] (0).
REQ-030 Reset mid-count: rst asserted 2 cycles into a debounce -> counter restarts, no pulse, press appears 6 cycles after rst deasserts if the button is still held.
